// File: rtl/static_sprite_scanner.sv
// Static-sprite lookup: scans the sprite table for the lowest-index enabled entry on a tile.
// Optional build macro SPRITE_OVERLAP_EN: full scans plus an overlap flag when >=2 entries match.
module static_sprite_scanner #(
   parameter  int unsigned NUM_SPRITES = 64,
   parameter  int unsigned COL_W       = 7,
   parameter  int unsigned ROW_W       = 7,
   parameter  int unsigned PAL_W       = 2,
   parameter  int unsigned CHAR_W      = 6,
   localparam int unsigned ADDR_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
   localparam int unsigned ENTRY_W     = 1 + COL_W + ROW_W + PAL_W + CHAR_W,
   localparam int unsigned OUT_W       = PAL_W + CHAR_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [COL_W-1:0]   collumn,
   input  logic [ROW_W-1:0]   row,
   input  logic               req,
   output logic               busy,
   output logic               done,
   output logic               men,
   output logic [OUT_W-1:0]   out,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [ENTRY_W-1:0] wr_data
`ifdef SPRITE_OVERLAP_EN
   ,
   output logic               overlap
`endif
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NUM_SPRITES - 1);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e             state_q;
   logic [ENTRY_W-1:0] sprite_tbl_q [NUM_SPRITES];
   logic [ENTRY_W-1:0] rd_q;
   logic [ADDR_W-1:0]  idx_q;
   logic [ADDR_W-1:0]  idx_nxt;
   logic [COL_W-1:0]   col_q;
   logic [ROW_W-1:0]   row_q;
   logic               match;
   logic               is_last;
`ifdef SPRITE_OVERLAP_EN
   logic               hit_q;
   logic               multi_q;
   logic [OUT_W-1:0]   hit_data_q;
`endif

   // rd_q holds entry idx_q; it was read the cycle before it is compared.
   always_comb begin
      idx_nxt = idx_q + ADDR_W'(1);
      is_last = (idx_q == LastIdx);
      match   = rd_q[ENTRY_W-1]
                && (rd_q[OUT_W+ROW_W +: COL_W] == col_q)
                && (rd_q[OUT_W +: ROW_W] == row_q);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_SPRITES); i++) sprite_tbl_q[i] <= '0;
      end else if (wr_en && (32'(wr_addr) < NUM_SPRITES)) begin
         sprite_tbl_q[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         rd_q       <= '0;
         idx_q      <= '0;
         col_q      <= '0;
         row_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         men        <= 1'b0;
         out        <= '0;
`ifdef SPRITE_OVERLAP_EN
         hit_q      <= 1'b0;
         multi_q    <= 1'b0;
         hit_data_q <= '0;
         overlap    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req) begin
                  col_q   <= collumn;
                  row_q   <= row;
                  rd_q    <= sprite_tbl_q[0];
                  idx_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StScan;
`ifdef SPRITE_OVERLAP_EN
                  hit_q   <= 1'b0;
                  multi_q <= 1'b0;
`endif
               end
            end
            StScan: begin
               if (!is_last) begin
                  rd_q  <= sprite_tbl_q[idx_nxt];
                  idx_q <= idx_nxt;
               end
`ifdef SPRITE_OVERLAP_EN
               if (match && !hit_q) begin
                  hit_q      <= 1'b1;
                  hit_data_q <= rd_q[OUT_W-1:0];
               end
               if (match && hit_q) multi_q <= 1'b1;
               if (is_last) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  men     <= hit_q | match;
                  out     <= hit_q ? hit_data_q : (match ? rd_q[OUT_W-1:0] : '0);
                  overlap <= multi_q | (match & hit_q);
               end
`else
               if (match || is_last) begin
                  state_q <= StDone;
                  done    <= 1'b1;
                  men     <= match;
                  out     <= match ? rd_q[OUT_W-1:0] : '0;
               end
`endif
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_static_sprite_scanner.sv
// Directed bench for static_sprite_scanner (64 entries, 7/7/2/6 field widths).
module tb_static_sprite_scanner;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       req = 1'b0;
   logic       wr_en = 1'b0;
   logic [6:0] collumn = '0;
   logic [6:0] row = '0;
   logic [5:0] wr_addr = '0;
   logic [22:0] wr_data = '0;
   logic       busy, done, men;
   logic [7:0] out;
`ifdef SPRITE_OVERLAP_EN
   logic       overlap;
`endif

   int total = 0;
   int bad = 0;

   always #5 clock = ~clock;

   static_sprite_scanner dut (
      .clock   (clock),
      .reset   (reset),
      .collumn (collumn),
      .row     (row),
      .req     (req),
      .busy    (busy),
      .done    (done),
      .men     (men),
      .out     (out),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
`ifdef SPRITE_OVERLAP_EN
      ,
      .overlap (overlap)
`endif
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_entry(input int addr, input bit en, input int c, input int r,
                              input int pal, input int chr);
      wr_addr = 6'(addr);
      wr_data = {en, 7'(c), 7'(r), 2'(pal), 6'(chr)};
      wr_en   = 1'b1;
      step();
      wr_en   = 1'b0;
   endtask

   // Returns n such that done is seen in cycle t+n (t = request cycle); 200 on timeout.
   task automatic lookup(input int c, input int r, output int n);
      collumn = 7'(c);
      row     = 7'(r);
      req     = 1'b1;
      step();
      req     = 1'b0;
      n       = 1;
      while (done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (men !== 1'b0) begin bad++; $display("FAIL reset_men: got %b want 0", men); end
      total++; if (out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", out); end
`ifdef SPRITE_OVERLAP_EN
      total++; if (overlap !== 1'b0) begin bad++; $display("FAIL reset_overlap: got %b want 0", overlap); end
`endif
   endtask

   task automatic test_miss_empty();
      int n;
      collumn = 7'd5;
      row     = 7'd3;
      req     = 1'b1;
      step();
      req     = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_t1: got %b want 1", busy); end
      n = 1;
      while (done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      total++; if (n != 65) begin bad++; $display("FAIL miss_latency: got %0d want 65", n); end
      total++; if (men !== 1'b0) begin bad++; $display("FAIL miss_men: got %b want 0", men); end
      total++; if (out !== 8'h00) begin bad++; $display("FAIL miss_out: got %h want 00", out); end
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_hit();
      int n;
      write_entry(10, 1'b1, 5, 3, 2, 6'h2A);
      lookup(5, 3, n);
`ifdef SPRITE_OVERLAP_EN
      total++; if (n != 65) begin bad++; $display("FAIL hit_latency: got %0d want 65", n); end
      total++; if (overlap !== 1'b0) begin bad++; $display("FAIL hit_overlap: got %b want 0", overlap); end
`else
      total++; if (n != 12) begin bad++; $display("FAIL hit_latency: got %0d want 12", n); end
`endif
      total++; if (men !== 1'b1) begin bad++; $display("FAIL hit_men: got %b want 1", men); end
      total++; if (out !== 8'hAA) begin bad++; $display("FAIL hit_out: got %h want AA", out); end
      step();
      step();
      total++; if (done !== 1'b0) begin bad++; $display("FAIL hit_done_pulse: got %b want 0", done); end
      total++; if (out !== 8'hAA || men !== 1'b1) begin
         bad++; $display("FAIL hit_hold: got men=%b out=%h want men=1 out=AA", men, out);
      end
   endtask

   task automatic test_boundary();
      int n;
      write_entry(0, 1'b1, 7, 7, 0, 6'h01);
      write_entry(63, 1'b1, 8, 8, 3, 6'h3F);
      lookup(7, 7, n);
`ifdef SPRITE_OVERLAP_EN
      total++; if (n != 65) begin bad++; $display("FAIL first_latency: got %0d want 65", n); end
`else
      total++; if (n != 2) begin bad++; $display("FAIL first_latency: got %0d want 2", n); end
`endif
      total++; if (men !== 1'b1 || out !== 8'h01) begin
         bad++; $display("FAIL first_result: got men=%b out=%h want men=1 out=01", men, out);
      end
      step();
      lookup(8, 8, n);
      total++; if (n != 65) begin bad++; $display("FAIL last_latency: got %0d want 65", n); end
      total++; if (men !== 1'b1 || out !== 8'hFF) begin
         bad++; $display("FAIL last_result: got men=%b out=%h want men=1 out=FF", men, out);
      end
      step();
   endtask

   task automatic test_priority();
      int n;
      write_entry(4, 1'b1, 1, 1, 1, 6'h11);
      write_entry(9, 1'b1, 1, 1, 3, 6'h22);
      lookup(1, 1, n);
`ifdef SPRITE_OVERLAP_EN
      total++; if (n != 65) begin bad++; $display("FAIL prio_latency: got %0d want 65", n); end
      total++; if (overlap !== 1'b1) begin bad++; $display("FAIL prio_overlap: got %b want 1", overlap); end
`else
      total++; if (n != 6) begin bad++; $display("FAIL prio_latency: got %0d want 6", n); end
`endif
      total++; if (men !== 1'b1 || out !== 8'h51) begin
         bad++; $display("FAIL prio_result: got men=%b out=%h want men=1 out=51", men, out);
      end
      step();
   endtask

   task automatic test_disabled();
      int n;
      write_entry(7, 1'b0, 2, 2, 3, 6'h3F);
      lookup(2, 2, n);
      total++; if (n != 65) begin bad++; $display("FAIL dis_latency: got %0d want 65", n); end
      total++; if (men !== 1'b0 || out !== 8'h00) begin
         bad++; $display("FAIL dis_result: got men=%b out=%h want men=0 out=00", men, out);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      int m;
      int extra;
      collumn = 7'd1;
      row     = 7'd1;
      req     = 1'b1;
      step();
      n = 1;
      while (done !== 1'b1 && n < 200) begin
         step();
         n++;
      end
`ifdef SPRITE_OVERLAP_EN
      total++; if (n != 65) begin bad++; $display("FAIL b2b_first: got %0d want 65", n); end
`else
      total++; if (n != 6) begin bad++; $display("FAIL b2b_first: got %0d want 6", n); end
`endif
      step();
      total++; if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL b2b_idle: got done=%b busy=%b want 0 0", done, busy);
      end
      step();
      req = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", busy); end
      m = 0;
      while (done !== 1'b1 && m < 200) begin
         step();
         m++;
      end
      total++; if (done !== 1'b1 || out !== 8'h51) begin
         bad++; $display("FAIL b2b_second: got done=%b out=%h want 1 51", done, out);
      end
      extra = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (done === 1'b1) extra++;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL b2b_no_queue: got %0d want 0", extra); end
   endtask

   task automatic test_reset_mid_scan();
      int n;
      int dones;
      collumn = 7'd9;
      row     = 7'd9;
      req     = 1'b1;
      step();
      req = 1'b0;
      n = 1;
      while (n < 20) begin
         step();
         n++;
      end
      reset = 1'b0;
      #1;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL abort_outputs: got busy=%b done=%b want 0 0", busy, done);
      end
      total++; if (men !== 1'b0 || out !== 8'h00) begin
         bad++; $display("FAIL abort_result: got men=%b out=%h want 0 00", men, out);
      end
`ifdef SPRITE_OVERLAP_EN
      total++; if (overlap !== 1'b0) begin bad++; $display("FAIL abort_overlap: got %b want 0", overlap); end
`endif
      step();
      step();
      reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 80; i++) begin
         step();
         if (done === 1'b1) dones++;
      end
      total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
      lookup(5, 3, n);
      total++; if (n != 65) begin bad++; $display("FAIL cleared_latency: got %0d want 65", n); end
      total++; if (men !== 1'b0 || out !== 8'h00) begin
         bad++; $display("FAIL cleared_result: got men=%b out=%h want 0 00", men, out);
      end
   endtask

   initial begin
      test_reset();
      test_miss_empty();
      test_hit();
      test_boundary();
      test_priority();
      test_disabled();
      test_back_to_back();
      test_reset_mid_scan();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
